// File: rtl/tilegame_pkg.sv
// tilegame_pkg: shared definitions for the tile-matching game.
//   - FSM state encodings (also the value shown on state_o / mode display)
//   - default board size and colour width
//   - default colour table, driven onto tile_colors by the board top level
//   - sat_inc8: saturating 8-bit increment used for the move counter
package tilegame_pkg;

  localparam int TG_NUM_TILES = 10;
  localparam int TG_COLOR_W   = 4;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_FIRST  = 3'd1;
  localparam logic [2:0] ST_WAIT_SECOND = 3'd2;
  localparam logic [2:0] ST_REVEAL      = 3'd3;
  localparam logic [2:0] ST_RESOLVE     = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;

  // Tile i colour at [i*4 +: 4]. Pairs: 0/7=1, 1/4=2, 2/6=3, 3/5=4, 8/9=5.
  localparam logic [TG_NUM_TILES*TG_COLOR_W-1:0] TG_DEFAULT_COLORS = {
    4'd5, 4'd5, 4'd1, 4'd3, 4'd4, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1
  };

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sw_edge_sync.sv
// sw_edge_sync: brings the raw tile switches into the CLOCK_50 domain and
// produces a one-cycle pulse per rising edge.
//   CLOCK_50  in   system clock
//   resetn    in   synchronous active-low reset
//   i_sw      in   raw asynchronous switches
//   o_rise    out  registered rising-edge pulse per switch
// Path: two synchroniser flops, then a registered edge stage, so a switch
// change sampled on edge k shows up on o_rise after edge k+2.
module sw_edge_sync #(
  parameter int WIDTH = 10
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_rise;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
          r_prev[gi] <= 1'b0;
          r_rise[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_sw[gi];
          r_sync[gi] <= r_meta[gi];
          r_prev[gi] <= r_sync[gi];
          r_rise[gi] <= r_sync[gi] & ~r_prev[gi];
        end
      end
    end
  endgenerate

  assign o_rise = r_rise;

endmodule

// File: rtl/tile_turn_controller.sv
// tile_turn_controller: sequences one player turn of the tile-matching game
// (first pick, second pick, timed reveal, resolve) and keeps the matched
// mask, move counter and game-complete flag.
//   CLOCK_50     in   system clock
//   resetn       in   synchronous active-low reset
//   start        in   pulse, begins a new game (IDLE/DONE only)
//   quit         in   pulse, abandons the game (wins over start)
//   sw           in   raw tile switches, one per tile
//   tile_colors  in   colour of tile i at [i*COLOR_W +: COLOR_W]
//   led          out  tile LEDs
//   color_a/show_a  out  first pick colour and its valid flag
//   color_b/show_b  out  second pick colour and its valid flag
//   moves        out  completed pair attempts, saturating at 255
//   all_matched  out  high in DONE
//   state_o      out  current FSM state
module tile_turn_controller
  import tilegame_pkg::*;
#(
  parameter int NUM_TILES     = TG_NUM_TILES,
  parameter int COLOR_W       = TG_COLOR_W,
  parameter int REVEAL_CYCLES = 50000000,
  parameter int BLINK_HALF    = 12500000
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic                         start,
  input  logic                         quit,
  input  logic [NUM_TILES-1:0]         sw,
  input  logic [NUM_TILES*COLOR_W-1:0] tile_colors,
  output logic [NUM_TILES-1:0]         led,
  output logic [COLOR_W-1:0]           color_a,
  output logic                         show_a,
  output logic [COLOR_W-1:0]           color_b,
  output logic                         show_b,
  output logic [7:0]                   moves,
  output logic                         all_matched,
  output logic [2:0]                   state_o
);

  localparam int IDX_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
  localparam int RC_W  = $clog2(REVEAL_CYCLES + 1);
  localparam int BC_W  = $clog2(BLINK_HALF + 1);
  localparam logic [RC_W-1:0] REVEAL_LOAD = RC_W'(REVEAL_CYCLES - 1);
  localparam logic [BC_W-1:0] BLINK_LAST  = BC_W'(BLINK_HALF - 1);

  logic [2:0]           r_state;
  logic [NUM_TILES-1:0] r_matched;
  logic [IDX_W-1:0]     r_first_idx;
  logic [IDX_W-1:0]     r_second_idx;
  logic [7:0]           r_moves;
  logic [RC_W-1:0]      r_reveal_cnt;
  logic [BC_W-1:0]      r_blink_cnt;
  logic                 r_blink_on;

  logic [NUM_TILES-1:0] w_rise;
  logic [NUM_TILES-1:0] w_pick_req;
  logic [NUM_TILES-1:0] w_first_oh;
  logic [NUM_TILES-1:0] w_second_oh;
  logic [NUM_TILES-1:0] w_mask_next;
  logic                 w_pick_valid;
  logic [IDX_W-1:0]     w_pick_idx;
  logic [COLOR_W-1:0]   w_color_first;
  logic [COLOR_W-1:0]   w_color_second;
  logic                 w_colors_equal;

  sw_edge_sync #(
    .WIDTH(NUM_TILES)
  ) u_sw_edge_sync (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .i_sw    (sw),
    .o_rise  (w_rise)
  );

  assign w_first_oh     = {{(NUM_TILES-1){1'b0}}, 1'b1} << r_first_idx;
  assign w_second_oh    = {{(NUM_TILES-1){1'b0}}, 1'b1} << r_second_idx;
  assign w_color_first  = tile_colors[r_first_idx*COLOR_W +: COLOR_W];
  assign w_color_second = tile_colors[r_second_idx*COLOR_W +: COLOR_W];
  assign w_colors_equal = (w_color_first == w_color_second);
  assign w_mask_next    = w_colors_equal ? (r_matched | w_first_oh | w_second_oh)
                                         : r_matched;

  // Matched tiles never pick; the held first tile cannot be picked again.
  always_comb begin
    w_pick_req = w_rise & ~r_matched;
    if (r_state == ST_WAIT_SECOND) begin
      w_pick_req = w_pick_req & ~w_first_oh;
    end
  end

  // Lowest index wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (w_pick_req[i]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_matched    <= '0;
      r_first_idx  <= '0;
      r_second_idx <= '0;
      r_moves      <= '0;
      r_reveal_cnt <= '0;
      r_blink_cnt  <= '0;
      r_blink_on   <= 1'b0;
    end else if (quit) begin
      // Mask and moves are deliberately kept so the display can still show them.
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state   <= ST_WAIT_FIRST;
            r_matched <= '0;
            r_moves   <= '0;
          end
        end
        ST_WAIT_FIRST: begin
          if (w_pick_valid) begin
            r_first_idx <= w_pick_idx;
            r_state     <= ST_WAIT_SECOND;
          end
        end
        ST_WAIT_SECOND: begin
          if (w_pick_valid) begin
            r_second_idx <= w_pick_idx;
            r_reveal_cnt <= REVEAL_LOAD;
            r_blink_cnt  <= '0;
            r_blink_on   <= 1'b1;
            r_state      <= ST_REVEAL;
          end
        end
        ST_REVEAL: begin
          if (r_reveal_cnt == '0) begin
            r_state <= ST_RESOLVE;
          end else begin
            r_reveal_cnt <= r_reveal_cnt - 1'b1;
          end
          if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
          end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
          end
        end
        ST_RESOLVE: begin
          r_moves   <= sat_inc8(r_moves);
          r_matched <= w_mask_next;
          r_state   <= (&w_mask_next) ? ST_DONE : ST_WAIT_FIRST;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    led     = '0;
    color_a = '0;
    show_a  = 1'b0;
    color_b = '0;
    show_b  = 1'b0;
    case (r_state)
      ST_WAIT_FIRST: led = r_matched;
      ST_WAIT_SECOND: begin
        led     = r_matched | w_first_oh;
        color_a = w_color_first;
        show_a  = 1'b1;
      end
      ST_REVEAL: begin
        led     = r_matched | (r_blink_on ? (w_first_oh | w_second_oh)
                                          : {NUM_TILES{1'b0}});
        color_a = w_color_first;
        show_a  = 1'b1;
        color_b = w_color_second;
        show_b  = 1'b1;
      end
      ST_RESOLVE: begin
        led     = r_matched;
        color_a = w_color_first;
        show_a  = 1'b1;
        color_b = w_color_second;
        show_b  = 1'b1;
      end
      ST_DONE: led = '1;
      default: ;
    endcase
  end

  assign moves       = r_moves;
  assign all_matched = (r_state == ST_DONE);
  assign state_o     = r_state;

endmodule

// File: tb/tb_tile_turn_controller.sv
module tb_tile_turn_controller;

  localparam int NT = 10;
  localparam int CW = 4;
  localparam int RC = 8;
  localparam int BH = 2;
  localparam int ALL = 32'h3FF;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic              quit = 1'b0;
  logic [NT-1:0]     sw = '0;
  logic [NT*CW-1:0]  tile_colors;
  logic [NT-1:0]     led;
  logic [CW-1:0]     color_a;
  logic              show_a;
  logic [CW-1:0]     color_b;
  logic              show_b;
  logic [7:0]        moves;
  logic              all_matched;
  logic [2:0]        state_o;

  // Reference colour table, independent of the design package.
  int colour_of [NT] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};

  // Behavioural model of the game progress.
  int model_mask  = 0;
  int model_moves = 0;

  int n_checks = 0;
  int n_fail   = 0;

  tile_turn_controller #(
    .NUM_TILES    (NT),
    .COLOR_W      (CW),
    .REVEAL_CYCLES(RC),
    .BLINK_HALF   (BH)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .start      (start),
    .quit       (quit),
    .sw         (sw),
    .tile_colors(tile_colors),
    .led        (led),
    .color_a    (color_a),
    .show_a     (show_a),
    .color_b    (color_b),
    .show_b     (show_b),
    .moves      (moves),
    .all_matched(all_matched),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int k;
    k = 0;
    while (state_o !== target && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {29'd0, state_o}, {29'd0, target});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_quit();
    quit = 1'b1;
    tick(1);
    quit = 1'b0;
  endtask

  task automatic new_game();
    pulse_start();
    model_mask  = 0;
    model_moves = 0;
    check("start_state", {29'd0, state_o}, 1);
    check("start_moves", {24'd0, moves}, 0);
    check("start_led", {22'd0, led}, 0);
  endtask

  task automatic pulse_sw(input int idx);
    sw[idx] = 1'b1;
    tick(5);
    sw[idx] = 1'b0;
    tick(4);
  endtask

  task automatic first_pick(input int a);
    pulse_sw(a);
    check("first_state", {29'd0, state_o}, 2);
    check("first_color_a", {28'd0, color_a}, colour_of[a]);
    check("first_show_a", {31'd0, show_a}, 1);
    check("first_led", {22'd0, led}, model_mask | (1 << a));
  endtask

  task automatic finish_turn(input int a, input int b);
    int exp_led;
    sw[b] = 1'b1;
    wait_state(3'd3, 8, "enter_reveal");
    check("reveal_show_b", {31'd0, show_b}, 1);
    check("reveal_color_b", {28'd0, color_b}, colour_of[b]);
    for (int c = 0; c < RC; c++) begin
      exp_led = model_mask | ((((c / BH) % 2) == 0) ? ((1 << a) | (1 << b)) : 0);
      check("reveal_led", {22'd0, led}, exp_led);
      if (c == 0) sw[b] = 1'b0;
      tick(1);
    end
    check("resolve_state", {29'd0, state_o}, 4);
    model_moves = (model_moves < 255) ? model_moves + 1 : 255;
    if (colour_of[a] == colour_of[b]) model_mask = model_mask | (1 << a) | (1 << b);
    tick(1);
    check("post_state", {29'd0, state_o}, (model_mask == ALL) ? 5 : 1);
    check("post_moves", {24'd0, moves}, model_moves);
    check("post_led", {22'd0, led}, model_mask);
    check("post_show_a", {31'd0, show_a}, 0);
    check("post_show_b", {31'd0, show_b}, 0);
    check("post_all_matched", {31'd0, all_matched}, (model_mask == ALL) ? 1 : 0);
  endtask

  task automatic turn(input int a, input int b);
    first_pick(a);
    finish_turn(a, b);
  endtask

  function automatic int rand_unmatched(input int mask, input int exclude);
    int t;
    t = int'($urandom_range(NT - 1));
    while (((mask >> t) & 1) == 1 || t == exclude) t = int'($urandom_range(NT - 1));
    return t;
  endfunction

  function automatic int partner(input int a);
    for (int j = 0; j < NT; j++) begin
      if (j != a && colour_of[j] == colour_of[a]) return j;
    end
    return a;
  endfunction

  initial begin
    int pa [5];
    int pb [5];
    int a;
    int b;
    int j;
    int tmp;

    for (int i = 0; i < NT; i++) tile_colors[i*CW +: CW] = colour_of[i][CW-1:0];

    // Reset state
    tick(3);
    check("rst_state", {29'd0, state_o}, 0);
    check("rst_led", {22'd0, led}, 0);
    check("rst_moves", {24'd0, moves}, 0);
    check("rst_show_a", {31'd0, show_a}, 0);
    check("rst_show_b", {31'd0, show_b}, 0);
    check("rst_color_a", {28'd0, color_a}, 0);
    check("rst_color_b", {28'd0, color_b}, 0);
    check("rst_all_matched", {31'd0, all_matched}, 0);
    resetn = 1'b1;
    tick(2);
    check("idle_state", {29'd0, state_o}, 0);

    // Matching pair 0/7
    new_game();
    turn(0, 7);
    check("pair07_mask", {22'd0, led}, 32'h081);

    // Mismatch 1/2 in a fresh game
    pulse_quit();
    new_game();
    turn(1, 2);
    check("mismatch_led", {22'd0, led}, 0);

    // Simultaneous picks of 3 and 5: lowest index wins
    sw[3] = 1'b1;
    sw[5] = 1'b1;
    tick(5);
    check("simul_state", {29'd0, state_o}, 2);
    check("simul_color_a", {28'd0, color_a}, 4);
    check("simul_show_a", {31'd0, show_a}, 1);
    check("simul_led", {22'd0, led}, 32'h008);
    sw[3] = 1'b0;
    tick(4);
    sw[3] = 1'b1;
    tick(5);
    check("repick_ignored", {29'd0, state_o}, 2);
    sw[3] = 1'b0;
    sw[5] = 1'b0;
    tick(4);
    check("fall_ignored", {29'd0, state_o}, 2);
    finish_turn(3, 5);

    // Full game with all pairs correct, random order
    pulse_quit();
    new_game();
    pa = '{0, 1, 2, 3, 8};
    pb = '{7, 4, 6, 5, 9};
    for (int i = 4; i > 0; i--) begin
      j = int'($urandom_range(i));
      tmp = pa[i]; pa[i] = pa[j]; pa[j] = tmp;
      tmp = pb[i]; pb[i] = pb[j]; pb[j] = tmp;
    end
    for (int i = 0; i < 5; i++) begin
      if ($urandom_range(1) == 1) turn(pa[i], pb[i]);
      else turn(pb[i], pa[i]);
    end
    check("full_state", {29'd0, state_o}, 5);
    check("full_all_matched", {31'd0, all_matched}, 1);
    check("full_led", {22'd0, led}, 32'h3FF);
    check("full_moves", {24'd0, moves}, 5);
    pulse_sw(0);
    check("done_pick_ignored", {29'd0, state_o}, 5);
    check("done_led_held", {22'd0, led}, 32'h3FF);

    // Randomised game with mismatches, started from DONE
    new_game();
    for (int t = 0; t < 60 && model_mask != ALL; t++) begin
      a = rand_unmatched(model_mask, -1);
      if ($urandom_range(1) == 1) b = partner(a);
      else b = rand_unmatched(model_mask, a);
      turn(a, b);
    end
    check("rand_game_done", {29'd0, state_o}, 5);
    check("rand_game_moves", {24'd0, moves}, model_moves);

    // Quit during REVEAL
    new_game();
    turn(0, 1);
    first_pick(2);
    sw[3] = 1'b1;
    wait_state(3'd3, 8, "quit_enter_reveal");
    tick(2);
    pulse_quit();
    sw[3] = 1'b0;
    check("quit_state", {29'd0, state_o}, 0);
    check("quit_led", {22'd0, led}, 0);
    check("quit_show_a", {31'd0, show_a}, 0);
    check("quit_show_b", {31'd0, show_b}, 0);
    check("quit_moves_held", {24'd0, moves}, 1);
    tick(4);

    // start and quit together: quit wins
    start = 1'b1;
    quit  = 1'b1;
    tick(1);
    start = 1'b0;
    quit  = 1'b0;
    check("start_quit_state", {29'd0, state_o}, 0);
    check("start_quit_moves", {24'd0, moves}, 1);

    // A switch already high at start is not a pick
    sw[4] = 1'b1;
    tick(6);
    new_game();
    tick(6);
    check("high_at_start", {29'd0, state_o}, 1);
    sw[4] = 1'b0;
    tick(5);
    check("high_fall_ignored", {29'd0, state_o}, 1);

    // Reset during REVEAL
    first_pick(0);
    sw[1] = 1'b1;
    wait_state(3'd3, 8, "rst_enter_reveal");
    tick(3);
    resetn = 1'b0;
    sw[1]  = 1'b0;
    tick(1);
    check("midrst_state", {29'd0, state_o}, 0);
    check("midrst_led", {22'd0, led}, 0);
    check("midrst_show_a", {31'd0, show_a}, 0);
    check("midrst_show_b", {31'd0, show_b}, 0);
    check("midrst_color_a", {28'd0, color_a}, 0);
    check("midrst_moves", {24'd0, moves}, 0);
    resetn = 1'b1;
    tick(RC + 4);
    check("midrst_no_resolve", {29'd0, state_o}, 0);

    // Saturation of the move counter
    new_game();
    for (int t = 0; t < 260; t++) begin
      a = int'($urandom_range(NT - 1));
      b = int'($urandom_range(NT - 1));
      while (colour_of[b] == colour_of[a]) b = int'($urandom_range(NT - 1));
      turn(a, b);
    end
    check("sat_moves", {24'd0, moves}, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
